// File: rtl/terra_pkg.sv
// Shared constants and types for the 68000/Z80 sound-latch bridge.
package terra_pkg;

    localparam int   SND_IRQ_DIV_DEFAULT = 512;
    localparam logic SND_LATCH_MARK      = 1'b1;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one flop plus AND gate, reset to "low not yet seen".
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    // Stores "input was low last cycle". Coming out of reset at 0 means a
    // level already high at release must drop before it can count as an edge.
    logic low_seen_q;
    logic low_seen_d;

    always_comb begin
        low_seen_d = ~d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) low_seen_q <= 1'b0;
        else          low_seen_q <= low_seen_d;
    end

    assign rise = d & low_seen_q;

endmodule

// File: rtl/sound_latch_bridge.sv
// 68000 -> Z80 sound latch with Z80 read/clear ports and a periodic Z80 INT
// that stays asserted until acknowledged by an M1+IORQ cycle.
module sound_latch_bridge
    import terra_pkg::*;
#(
    parameter int IRQ_DIV = SND_IRQ_DIV_DEFAULT,
    parameter int CNT_W   = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sound_latch_cs,
    input  logic       m68k_rw,
    input  logic       m68k_lds_n,
    input  logic [7:0] m68k_din,
    input  logic       z80_cen,
    input  logic       z80_latch_r_cs,
    input  logic       z80_latch_clr_cs,
    input  logic       z80_rd_n,
    input  logic       z80_wr_n,
    input  logic       z80_iorq_n,
    input  logic       z80_m1_n,
    output logic [7:0] z80_dout,
    output logic       z80_irq_n,
    output logic       latch_full
);

    logic wstb, clr_stb, ack_stb;
    logic wr_rise, clr_rise, ack_rise;
    logic din_unused;

    assign wstb       = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
    assign clr_stb    = z80_latch_clr_cs & ~z80_wr_n;
    assign ack_stb    = ~z80_iorq_n & ~z80_m1_n;
    assign din_unused = m68k_din[7];

    rise_detect u_wr_rise  (.clk(clk), .reset_n(reset_n), .d(wstb),    .rise(wr_rise));
    rise_detect u_clr_rise (.clk(clk), .reset_n(reset_n), .d(clr_stb), .rise(clr_rise));
    rise_detect u_ack_rise (.clk(clk), .reset_n(reset_n), .d(ack_stb), .rise(ack_rise));

    logic [7:0]       latch_q, latch_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    irq_state_e       state_q, state_d;

    always_comb begin
        latch_d = latch_q;
        full_d  = full_q;
        if (clr_rise) begin
            latch_d = 8'h00;
            full_d  = 1'b0;
        end
        // Write is applied last so it wins over a same-cycle clear.
        if (wr_rise) begin
            latch_d = {m68k_din[6:0], SND_LATCH_MARK};
            full_d  = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        wrap  = z80_cen && (cnt_q == CNT_W'(IRQ_DIV - 1));
        if (z80_cen) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE: if (wrap) state_d = IRQ_PEND;
            IRQ_PEND: if (ack_rise && !wrap) state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch_q <= 8'h00;
            full_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IRQ_IDLE;
        end else begin
            latch_q <= latch_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign z80_dout   = (z80_latch_r_cs && !z80_rd_n) ? latch_q : 8'h00;
    assign z80_irq_n  = (state_q != IRQ_PEND);
    assign latch_full = full_q;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Directed bench for sound_latch_bridge with IRQ_DIV=8.
module tb_sound_latch_bridge;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sound_latch_cs, m68k_rw, m68k_lds_n;
    logic [7:0] m68k_din;
    logic       z80_cen, z80_latch_r_cs, z80_latch_clr_cs;
    logic       z80_rd_n, z80_wr_n, z80_iorq_n, z80_m1_n;
    logic [7:0] z80_dout;
    logic       z80_irq_n, latch_full;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sound_latch_bridge #(.IRQ_DIV(8), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .sound_latch_cs(sound_latch_cs), .m68k_rw(m68k_rw), .m68k_lds_n(m68k_lds_n),
        .m68k_din(m68k_din), .z80_cen(z80_cen),
        .z80_latch_r_cs(z80_latch_r_cs), .z80_latch_clr_cs(z80_latch_clr_cs),
        .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n), .z80_iorq_n(z80_iorq_n), .z80_m1_n(z80_m1_n),
        .z80_dout(z80_dout), .z80_irq_n(z80_irq_n), .latch_full(latch_full)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic m68k_wr(input logic on, input logic [7:0] d);
        sound_latch_cs = on;
        m68k_rw        = ~on;
        m68k_lds_n     = ~on;
        m68k_din       = d;
    endtask

    task automatic z80_rd(input logic on);
        z80_latch_r_cs = on;
        z80_rd_n       = ~on;
    endtask

    task automatic z80_clr(input logic on);
        z80_latch_clr_cs = on;
        z80_wr_n         = ~on;
    endtask

    task automatic z80_ack(input logic on);
        z80_iorq_n = ~on;
        z80_m1_n   = ~on;
    endtask

    // Three idle clocks then one enable clock; the enable is consumed at the final edge.
    task automatic one_enable();
        z80_cen = 1'b0;
        repeat (3) cyc();
        z80_cen = 1'b1;
        cyc();
        z80_cen = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        z80_rd(1'b1);
        #2;
        n_chk++; if (z80_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", z80_dout); end
        n_chk++; if (latch_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", latch_full); end
        n_chk++; if (z80_irq_n !== 1'b1) begin n_fail++; $display("FAIL reset_irq_n: got %b want 1", z80_irq_n); end
        z80_rd(1'b0);
        reset_n = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_write_capture();
        m68k_wr(1'b1, 8'h5A);
        cyc();
        n_chk++; if (latch_full !== 1'b1) begin n_fail++; $display("FAIL wr_full: got %b want 1", latch_full); end
        // Data changes while the strobe is still held: must not be recaptured.
        m68k_din = 8'h12;
        repeat (3) cyc();
        m68k_wr(1'b0, 8'h00);
        z80_rd(1'b1);
        #1;
        n_chk++; if (z80_dout !== 8'hB5) begin n_fail++; $display("FAIL wr_once_dout: got %h want b5", z80_dout); end
        z80_rd(1'b0);
        #1;
        n_chk++; if (z80_dout !== 8'h00) begin n_fail++; $display("FAIL dout_idle: got %h want 00", z80_dout); end
        cyc();
    endtask

    task automatic test_read_clear();
        z80_rd(1'b1);
        cyc();
        n_chk++; if (z80_dout !== 8'hB5) begin n_fail++; $display("FAIL rd_dout: got %h want b5", z80_dout); end
        n_chk++; if (latch_full !== 1'b1) begin n_fail++; $display("FAIL rd_full: got %b want 1", latch_full); end
        z80_rd(1'b0);
        z80_clr(1'b1);
        cyc();
        n_chk++; if (latch_full !== 1'b0) begin n_fail++; $display("FAIL clr_full: got %b want 0", latch_full); end
        z80_clr(1'b0);
        z80_rd(1'b1);
        #1;
        n_chk++; if (z80_dout !== 8'h00) begin n_fail++; $display("FAIL clr_dout: got %h want 00", z80_dout); end
        z80_rd(1'b0);
        cyc();
    endtask

    task automatic test_collision();
        m68k_wr(1'b1, 8'h03);
        z80_clr(1'b1);
        z80_rd(1'b1);
        #1;
        n_chk++; if (z80_dout !== 8'h00) begin n_fail++; $display("FAIL rd_old_on_wr: got %h want 00", z80_dout); end
        cyc();
        n_chk++; if (z80_dout !== 8'h07) begin n_fail++; $display("FAIL coll_dout: got %h want 07", z80_dout); end
        n_chk++; if (latch_full !== 1'b1) begin n_fail++; $display("FAIL coll_full: got %b want 1", latch_full); end
        m68k_wr(1'b0, 8'h00);
        z80_clr(1'b0);
        z80_rd(1'b0);
        cyc();
    endtask

    task automatic test_irq_period();
        do_reset();
        for (int e = 1; e <= 7; e++) one_enable();
        n_chk++; if (z80_irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_before_8: got %b want 1", z80_irq_n); end
        one_enable();
        n_chk++; if (z80_irq_n !== 1'b0) begin n_fail++; $display("FAIL irq_at_8: got %b want 0", z80_irq_n); end
        for (int p = 0; p < 3; p++) begin
            for (int e = 0; e < 8; e++) one_enable();
            n_chk++; if (z80_irq_n !== 1'b0) begin n_fail++; $display("FAIL irq_held_p%0d: got %b want 0", p, z80_irq_n); end
        end
        z80_ack(1'b1);
        cyc();
        n_chk++; if (z80_irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_ack: got %b want 1", z80_irq_n); end
        z80_ack(1'b0);
        cyc();
    endtask

    task automatic test_ack_collision();
        // Counter is at 0 here; seven enables bring it to 7.
        for (int e = 0; e < 7; e++) one_enable();
        n_chk++; if (z80_irq_n !== 1'b1) begin n_fail++; $display("FAIL ackc_pre: got %b want 1", z80_irq_n); end
        repeat (2) cyc();
        z80_cen = 1'b1;
        z80_ack(1'b1);
        cyc();
        n_chk++; if (z80_irq_n !== 1'b0) begin n_fail++; $display("FAIL ackc_set_wins: got %b want 0", z80_irq_n); end
        z80_cen = 1'b0;
        cyc();
        n_chk++; if (z80_irq_n !== 1'b0) begin n_fail++; $display("FAIL ackc_level_held: got %b want 0", z80_irq_n); end
        z80_ack(1'b0);
        cyc();
    endtask

    task automatic test_reset_midop();
        m68k_wr(1'b1, 8'h11);
        cyc();
        n_chk++; if (latch_full !== 1'b1) begin n_fail++; $display("FAIL rst_pre_full: got %b want 1", latch_full); end
        n_chk++; if (z80_irq_n !== 1'b0) begin n_fail++; $display("FAIL rst_pre_irq: got %b want 0", z80_irq_n); end
        reset_n = 1'b0;
        z80_rd(1'b1);
        #1;
        n_chk++; if (latch_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", latch_full); end
        n_chk++; if (z80_irq_n !== 1'b1) begin n_fail++; $display("FAIL rst_irq: got %b want 1", z80_irq_n); end
        n_chk++; if (z80_dout !== 8'h00) begin n_fail++; $display("FAIL rst_dout: got %h want 00", z80_dout); end
        cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        n_chk++; if (latch_full !== 1'b0) begin n_fail++; $display("FAIL rst_held_strobe: got %b want 0", latch_full); end
        n_chk++; if (z80_dout !== 8'h00) begin n_fail++; $display("FAIL rst_held_dout: got %h want 00", z80_dout); end
        m68k_wr(1'b0, 8'h11);
        cyc();
        m68k_wr(1'b1, 8'h11);
        cyc();
        n_chk++; if (latch_full !== 1'b1) begin n_fail++; $display("FAIL rst_rewrite_full: got %b want 1", latch_full); end
        n_chk++; if (z80_dout !== 8'h23) begin n_fail++; $display("FAIL rst_rewrite_dout: got %h want 23", z80_dout); end
        m68k_wr(1'b0, 8'h00);
        z80_rd(1'b0);
        // Counter restarted from 0 after release: 7 enables must not raise INT.
        for (int e = 0; e < 7; e++) one_enable();
        n_chk++; if (z80_irq_n !== 1'b1) begin n_fail++; $display("FAIL rst_cnt_restart: got %b want 1", z80_irq_n); end
        one_enable();
        n_chk++; if (z80_irq_n !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_wrap: got %b want 0", z80_irq_n); end
    endtask

    initial begin
        reset_n = 1'b0;
        m68k_wr(1'b0, 8'h00);
        z80_cen = 1'b0;
        z80_rd(1'b0);
        z80_clr(1'b0);
        z80_ack(1'b0);
        test_reset();
        test_write_capture();
        test_read_clear();
        test_collision();
        test_irq_period();
        test_ack_collision();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
